pipelined_rca: RTL and testbench

PIPELINED_RCA -- requirements
Module: pipelined_rca

---
 rtl/pipelined_rca_pkg.sv | 8 +
 rtl/pipelined_rca_rca_slice.sv | 27 ++
 rtl/pipelined_rca.sv | 116 +++++++++++
 tb/tb_pipelined_rca.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_rca_pkg.sv
// rtl/pipelined_rca_pkg.sv - shared sizing constants for the pipelined ripple-carry adder
package pipelined_rca_pkg;

    localparam int DEFAULT_N      = 16;
    localparam int DEFAULT_STAGES = 4;
    localparam int DEFAULT_W      = DEFAULT_N / DEFAULT_STAGES;

endpackage

// File: rtl/pipelined_rca_rca_slice.sv
// rtl/pipelined_rca_rca_slice.sv - combinational W-bit ripple-carry adder slice
module rca_slice
    import pipelined_rca_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W:0] carry;

    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < W; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[W];
    end

endmodule

// File: rtl/pipelined_rca.sv
// rtl/pipelined_rca.sv - N-bit add/subtract split into STAGES registered ripple slices
// Each stage consumes the low slice of the still-pending operands and appends its sum slice.
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int W = N / STAGES;

    if (N % STAGES != 0) begin : g_bad_cfg
        $error("pipelined_rca: N must be a multiple of STAGES");
    end

    logic         advance;
    logic [N-1:0] b_eff;
    logic         c0;

    assign b_eff = b ^ {N{sub}};
    assign c0    = cin ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int REM = N - k * W;

        logic [REM-1:0]       op_a;
        logic [REM-1:0]       op_b;
        logic                 c_in;
        logic                 v_in;
        logic [W-1:0]         s_slice;
        logic                 c_slice;
        logic [(k+1)*W-1:0]   sum_d;
        logic [(k+1)*W-1:0]   sum_q;
        logic                 carry_q;
        logic                 valid_q;

        if (k == 0) begin : g_head
            assign op_a  = a;
            assign op_b  = b_eff;
            assign c_in  = c0;
            assign v_in  = in_valid;
            assign sum_d = s_slice;
        end else begin : g_tail
            assign op_a  = g_stg[k-1].g_fwd.rem_a_q;
            assign op_b  = g_stg[k-1].g_fwd.rem_b_q;
            assign c_in  = g_stg[k-1].carry_q;
            assign v_in  = g_stg[k-1].valid_q;
            assign sum_d = {s_slice, g_stg[k-1].sum_q};
        end

        rca_slice #(.W(W)) u_slice (
            .a_i    (op_a[W-1:0]),
            .b_i    (op_b[W-1:0]),
            .cin_i  (c_in),
            .sum_o  (s_slice),
            .cout_o (c_slice)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= v_in;
                carry_q <= c_slice;
                sum_q   <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Unconsumed operand bits travel alongside their transaction; no reset needed.
            logic [REM-W-1:0] rem_a_q;
            logic [REM-W-1:0] rem_b_q;

            always_ff @(posedge clk) begin
                if (advance) begin
                    rem_a_q <= op_a[REM-1:W];
                    rem_b_q <= op_b[REM-1:W];
                end
            end
        end else begin : g_last
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= (op_a[REM-1] == op_b[REM-1]) && (s_slice[W-1] != op_a[REM-1]);
                end
            end
        end
    end

    assign advance   = !g_stg[STAGES-1].valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = g_stg[STAGES-1].valid_q;
    assign sum       = g_stg[STAGES-1].sum_q;
    assign cout      = g_stg[STAGES-1].carry_q;
    assign ovf       = g_stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// tb/tb_pipelined_rca.sv - directed self-checking bench for pipelined_rca (N=16, STAGES=4)
module tb_pipelined_rca;

    localparam int N      = 16;
    localparam int STAGES = 4;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [N-1:0] a         = '0;
    logic [N-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipelined_rca #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Drives one transaction and waits (bounded) for its result; lat counts the acceptance edge as 1.
    task automatic run_one(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                           input logic tsub, output logic [15:0] rs, output logic rc,
                           output logic ro, output int lat);
        a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        rs = sum; rc = cout; ro = ovf;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h0001;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, cout, ovf, sum} !== {1'b0, 1'b0, 1'b0, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset_outputs got valid=%b cout=%b ovf=%b sum=%h want 0 0 0 0000",
                     out_valid, cout, ovf, sum);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_ghost cycle %0d got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_add();
        vec_t        tbl[3];
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        tbl[0] = '{16'h0005, 16'h000B, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_one(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, rs, rc, ro, lat);
            vectors++;
            if ({rs, rc, ro} !== {tbl[i].s, tbl[i].c, tbl[i].o}) begin
                miscompares++;
                $display("FAIL add_%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         i, rs, rc, ro, tbl[i].s, tbl[i].c, tbl[i].o);
            end
            vectors++;
            if (lat != 4) begin
                miscompares++;
                $display("FAIL add_latency_%0d got %0d want 4", i, lat);
            end
        end
    endtask

    task automatic test_sub_ovf();
        vec_t        tbl[4];
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        tbl[0] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_one(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, rs, rc, ro, lat);
            vectors++;
            if ({rs, rc, ro, lat} !== {tbl[i].s, tbl[i].c, tbl[i].o, 32'sd4}) begin
                miscompares++;
                $display("FAIL subovf_%0d got sum=%h cout=%b ovf=%b lat=%0d want sum=%h cout=%b ovf=%b lat=4",
                         i, rs, rc, ro, lat, tbl[i].s, tbl[i].c, tbl[i].o);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t        tbl[8];
        int          in_idx    = 0;
        int          out_idx   = 0;
        int          cyc       = 0;
        int          stall_cnt = 0;
        logic        stalled_prev = 1'b0;
        logic [15:0] held_sum  = '0;
        logic        held_c    = 1'b0;
        logic        held_o    = 1'b0;
        tbl[0] = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0};
        tbl[1] = '{16'hF000, 16'h1000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h0100, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0};
        tbl[4] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[5] = '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{16'h00FF, 16'h0F0F, 1'b0, 1'b0, 16'h100E, 1'b0, 1'b0};
        // cyc-1 is the cycle number counted from the first acceptance edge
        while (out_idx < 8 && cyc < 40) begin
            out_ready = !((cyc - 1) >= 3 && (cyc - 1) <= 5);
            in_valid  = (in_idx < 8);
            if (in_idx < 8) begin
                a = tbl[in_idx].a; b = tbl[in_idx].b; cin = tbl[in_idx].cin; sub = tbl[in_idx].sub;
            end
            #1;
            vectors++;
            if (in_ready !== (!out_valid || out_ready)) begin
                miscompares++;
                $display("FAIL b2b_in_ready cycle %0d got %b want %b", cyc, in_ready, !out_valid || out_ready);
            end
            if (stalled_prev) begin
                vectors++;
                if ({out_valid, sum, cout, ovf} !== {1'b1, held_sum, held_c, held_o}) begin
                    miscompares++;
                    $display("FAIL b2b_hold cycle %0d got valid=%b sum=%h cout=%b ovf=%b want 1 %h %b %b",
                             cyc, out_valid, sum, cout, ovf, held_sum, held_c, held_o);
                end
            end
            if (out_valid && !out_ready) stall_cnt++;
            if (out_valid && out_ready) begin
                vectors++;
                if ({sum, cout, ovf} !== {tbl[out_idx].s, tbl[out_idx].c, tbl[out_idx].o}) begin
                    miscompares++;
                    $display("FAIL b2b_result_%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                             out_idx, sum, cout, ovf, tbl[out_idx].s, tbl[out_idx].c, tbl[out_idx].o);
                end
                out_idx++;
            end
            if (in_valid && in_ready) in_idx++;
            stalled_prev = out_valid && !out_ready;
            held_sum = sum; held_c = cout; held_o = ovf;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (out_idx != 8) begin
            miscompares++;
            $display("FAIL b2b_count got %0d results want 8", out_idx);
        end
        vectors++;
        if (stall_cnt != 3) begin
            miscompares++;
            $display("FAIL b2b_stall_cycles got %0d want 3", stall_cnt);
        end
        vectors++;
        if (cyc != 15) begin
            miscompares++;
            $display("FAIL b2b_throughput got %0d cycles want 15", cyc);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midflight();
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        int          seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'h0101 * 16'(i + 1); b = 16'h0011; cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_precondition got out_valid=%b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL midrst_async got valid=%b sum=%h cout=%b ovf=%b in_ready=%b want 0 0000 0 0 1",
                     out_valid, sum, cout, ovf, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL midrst_discard got %0d results want 0", seen);
        end
        run_one(16'h2468, 16'h1357, 1'b0, 1'b0, rs, rc, ro, lat);
        vectors++;
        if ({rs, rc, ro, lat} !== {16'h37BF, 1'b0, 1'b0, 32'sd4}) begin
            miscompares++;
            $display("FAIL midrst_next got sum=%h cout=%b ovf=%b lat=%0d want sum=37bf cout=0 ovf=0 lat=4",
                     rs, rc, ro, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_ovf();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
